se_stream_feeder: RTL and testbench
===================================

// Module: se_stream_feeder
// PURPOSE
// Initiator for the SE block's load/stream interface (the top_all_layers port set).
// Reads conv1 and conv2 weights, then the input feature map, from a 1-cycle-latency
// local memory. Drives load_kernel_conv1/2, input_valid and in_data, then counts SE
// outputs and forwards them until a full tensor is received. Sits between the
// on-chip buffer and the SE layer, replacing software sequencing.
// PARAMETERS
// DATA_WIDTH      16    width of weights, pixels and SE outputs
// IN_CHANNELS     16    SE input channels
// REDUCTION       4     SE channel reduction; NW = IN_CHANNELS*(IN_CHANNELS/REDUCTION) weights per conv
// IN_HEIGHT       8     feature map height
// IN_WIDTH        8     feature map width; NP = IN_CHANNELS*IN_HEIGHT*IN_WIDTH
// ADDR_WIDTH      12    memory address width; must hold 2*NW+NP-1
// TIMEOUT_CYCLES  4096  drain watchdog limit (used only with SE_FEEDER_TIMEOUT_EN)
// PORTS
// clk                in   1           clock, rising edge
// rst                in   1           asynchronous reset, active-high
// start              in   1           start pulse, accepted only in IDLE
// busy               out  1           high in every state except IDLE
// done               out  1           one-cycle pulse on completion
// error              out  1           sticky timeout flag, cleared by start/rst
// mem_rd_en          out  1           memory read strobe
// mem_addr           out  ADDR_WIDTH  read address; data returns next cycle
// mem_rd_data        in   DATA_WIDTH  read data
// in_data            out  DATA_WIDTH  to SE in_data
// load_kernel_conv1  out  1           to SE conv1 weight load
// load_kernel_conv2  out  1           to SE conv2 weight load
// input_valid        out  1           to SE pixel-stream valid
// se_out_valid       in   1           from SE out_valid
// se_out_data        in   DATA_WIDTH  from SE out_data
// result_valid       out  1           registered copy of accepted SE output
// result_data        out  DATA_WIDTH  registered copy of se_out_data
// out_count          out  16          SE outputs accepted this run
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately.
// - Memory map: conv1 weights at 0..NW-1, conv2 weights at NW..2NW-1, pixels at 2NW..2NW+NP-1.
// - FSM: IDLE -> W1_SETUP -> W1_LOAD -> W1_HOLD -> GAP -> W2_SETUP -> W2_LOAD -> W2_HOLD -> STREAM -> DRAIN -> DONE -> IDLE.
// - IDLE: start=1 clears out_count/error and moves to W1_SETUP. start while busy is ignored.
// - W1_SETUP (1 cycle): load_kernel_conv1=1, mem_rd_en=1, mem_addr=0. in_data=0.
// - W1_LOAD (NW cycles): load_kernel_conv1=1, in_data=mem_rd_data (weight k in cycle k).
//   The address for k+1 is issued in the same cycle. No read is issued in the last cycle.
// - W1_HOLD (1 cycle): load_kernel_conv1 stays 1, in_data holds the last weight.
//   GAP (1 cycle): all SE controls 0.
// - W2_SETUP/W2_LOAD/W2_HOLD: same as the conv1 states on load_kernel_conv2, base address NW.
//   The first pixel read (address 2NW) is issued in the W2_HOLD cycle.
// - STREAM (NP cycles): input_valid=1, in_data=pixel p in cycle p; never stalls. Then DRAIN.
// - load_kernel_conv1, load_kernel_conv2 and input_valid are never high together.
//   in_data=0 whenever none is high.
// - Outputs: se_out_valid is accepted only in STREAM/DRAIN while out_count<NP.
//   An accepted output sets result_valid/result_data on the next edge and increments out_count.
//   Outputs in any other state, or beyond NP, are dropped.
// - DRAIN exits to DONE in the cycle out_count reaches NP. If the NP-th output arrives in
//   the last STREAM cycle, go straight to DONE.
// - DONE: done=1 for one cycle, then IDLE; out_count holds until the next start.
// CONFIGURATION
// SE_FEEDER_TIMEOUT_EN defined: a DRAIN counter resets on each accepted output. When it
//   reaches TIMEOUT_CYCLES: error=1, go to DONE (done still pulses), out_count keeps the partial total.
// Not defined: DRAIN waits indefinitely; error tied 0; no counter logic.
// TESTING
// 1 Defaults; mem[a]=a; start; SE model returns NP outputs -> setup cycle with load1=1, in_data=0.
//   Then 64 cycles of in_data=0..63 (load1 high 66 cycles), 1 gap, load2 with 64..127.
//   Then input_valid high 1024 cycles with 128..1151; done after the 1024th output; out_count=1024.
// 2 start pulsed during W1_LOAD and STREAM -> ignored; address sequence unchanged.
// 3 rst asserted in STREAM cycle 300 -> all outputs 0 same cycle; new start replays from address 0.
// 4 se_out_valid pulsed in IDLE/GAP, plus 1030 outputs in DRAIN -> first 1024 counted,
//   extras and pre-stream pulses dropped.
// 5 TIMEOUT_EN, TIMEOUT_CYCLES=16, SE model stops after 500 outputs -> 16 cycles later error=1.
//   done pulses, out_count=500.
// 6 Final output coincident with last STREAM cycle -> DONE next cycle, no DRAIN cycles.

Source files
------------

// File: rtl/se_stream_feeder.sv
// se_stream_feeder: sequences the SE block's load/stream interface from a local memory.
// Loads conv1 weights, then conv2 weights, then streams the input feature map. It then
// forwards SE outputs until a full tensor of NP outputs has been accepted.
// Optional feature: define SE_FEEDER_TIMEOUT_EN to enable the DRAIN watchdog that
// raises a sticky error and finishes the run when SE outputs stop arriving.
module se_stream_feeder #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned IN_CHANNELS    = 16,
    parameter int unsigned REDUCTION      = 4,
    parameter int unsigned IN_HEIGHT      = 8,
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  load_kernel_conv1,
    output logic                  load_kernel_conv2,
    output logic                  input_valid,
    input  logic                  se_out_valid,
    input  logic [DATA_WIDTH-1:0] se_out_data,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic [15:0]           out_count
);

    localparam int unsigned NW = IN_CHANNELS * (IN_CHANNELS / REDUCTION);
    localparam int unsigned NP = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] W2Base  = ADDR_WIDTH'(NW);
    localparam logic [ADDR_WIDTH-1:0] PxBase  = ADDR_WIDTH'(2 * NW);
    localparam logic [ADDR_WIDTH-1:0] LastW   = ADDR_WIDTH'(NW - 1);
    localparam logic [ADDR_WIDTH-1:0] LastP   = ADDR_WIDTH'(NP - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [15:0]           NpCount = 16'(NP);

    typedef enum logic [3:0] {
        StIdle, StW1Setup, StW1Load, StW1Hold, StGap,
        StW2Setup, StW2Load, StW2Hold, StStream, StDrain, StDone
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  hold_q;
    logic [15:0]            out_count_q, out_count_d;
    logic                   result_valid_q;
    logic [DATA_WIDTH-1:0]  result_data_q;
    logic                   accept;

`ifdef SE_FEEDER_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    logic        error_q, error_d;
    logic [31:0] timer_q, timer_d;
`endif

    // SE outputs only count while the pixel stream is live and the tensor is incomplete.
    always_comb begin
        accept = se_out_valid && (state_q == StStream || state_q == StDrain) &&
                 (out_count_q < NpCount);
    end

    // Next-state, memory read and SE control decode.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        out_count_d       = accept ? out_count_q + 16'd1 : out_count_q;
        mem_rd_en         = 1'b0;
        mem_addr          = '0;
        in_data           = '0;
        load_kernel_conv1 = 1'b0;
        load_kernel_conv2 = 1'b0;
        input_valid       = 1'b0;
`ifdef SE_FEEDER_TIMEOUT_EN
        error_d           = error_q;
        timer_d           = (state_q == StDrain && !accept) ? timer_q + 32'd1 : 32'd0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StW1Setup;
                    out_count_d = '0;
`ifdef SE_FEEDER_TIMEOUT_EN
                    error_d     = 1'b0;
`endif
                end
            end
            StW1Setup: begin
                load_kernel_conv1 = 1'b1;
                mem_rd_en         = 1'b1;
                mem_addr          = '0;
                cnt_d             = '0;
                state_d           = StW1Load;
            end
            StW1Load: begin
                load_kernel_conv1 = 1'b1;
                in_data           = mem_rd_data;
                if (cnt_q == LastW) begin
                    state_d = StW1Hold;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_addr  = cnt_q + AddrOne;
                    cnt_d     = cnt_q + AddrOne;
                end
            end
            StW1Hold: begin
                load_kernel_conv1 = 1'b1;
                in_data           = hold_q;
                state_d           = StGap;
            end
            StGap: begin
                state_d = StW2Setup;
            end
            StW2Setup: begin
                load_kernel_conv2 = 1'b1;
                mem_rd_en         = 1'b1;
                mem_addr          = W2Base;
                cnt_d             = '0;
                state_d           = StW2Load;
            end
            StW2Load: begin
                load_kernel_conv2 = 1'b1;
                in_data           = mem_rd_data;
                if (cnt_q == LastW) begin
                    state_d = StW2Hold;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_addr  = W2Base + cnt_q + AddrOne;
                    cnt_d     = cnt_q + AddrOne;
                end
            end
            StW2Hold: begin
                // Prefetch the first pixel so STREAM runs without a bubble.
                load_kernel_conv2 = 1'b1;
                in_data           = hold_q;
                mem_rd_en         = 1'b1;
                mem_addr          = PxBase;
                cnt_d             = '0;
                state_d           = StStream;
            end
            StStream: begin
                input_valid = 1'b1;
                in_data     = mem_rd_data;
                if (cnt_q == LastP) begin
                    state_d = (out_count_d == NpCount) ? StDone : StDrain;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_addr  = PxBase + cnt_q + AddrOne;
                    cnt_d     = cnt_q + AddrOne;
                end
            end
            StDrain: begin
                if (out_count_d == NpCount) begin
                    state_d = StDone;
`ifdef SE_FEEDER_TIMEOUT_EN
                end else if (!accept && timer_q == TimeoutLast) begin
                    error_d = 1'b1;
                    state_d = StDone;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and captured SE output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            out_count_q    <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_count_q    <= out_count_d;
            result_valid_q <= accept;
            if (accept) begin
                result_data_q <= se_out_data;
            end
        end
    end

    // Remember the last weight read so the HOLD cycle can repeat it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (state_q == StW1Load || state_q == StW2Load) begin
            hold_q <= mem_rd_data;
        end
    end

`ifdef SE_FEEDER_TIMEOUT_EN
    // Drain watchdog and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
            timer_q <= '0;
        end else begin
            error_q <= error_d;
            timer_q <= timer_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign out_count    = out_count_q;

endmodule

// File: tb/tb_se_stream_feeder.sv
// Scoreboard bench for se_stream_feeder: the stimulus pushes the expected SE control
// stream and expected results into queues; negedge monitors pop and compare.
module tb_se_stream_feeder;

    localparam int NW = 64;
    localparam int NP = 1024;
    localparam int TO = 16;

    typedef struct packed {
        logic [1:0]  kind;   // 1 = conv1 load, 2 = conv2 load, 3 = pixel
        logic [15:0] data;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, mem_rd_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_rd_data = 16'h0;
    logic [15:0] in_data;
    logic        load_kernel_conv1, load_kernel_conv2, input_valid;
    logic        se_out_valid = 1'b0;
    logic [15:0] se_out_data = 16'h0;
    logic        result_valid;
    logic [15:0] result_data;
    logic [15:0] out_count;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_t        exp_q[$];
    logic [15:0] res_q[$];

    // SE model controls
    bit se_run = 0, se_defer = 0, se_idle_pulse = 0, se_gap_pulse = 0;
    int se_lat = 0, se_total = 0, in_seen = 0, out_sent = 0, mcyc = 0;
    int in_times[$];

    always #5 clk = ~clk;

    se_stream_feeder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .mem_rd_en         (mem_rd_en),
        .mem_addr          (mem_addr),
        .mem_rd_data       (mem_rd_data),
        .in_data           (in_data),
        .load_kernel_conv1 (load_kernel_conv1),
        .load_kernel_conv2 (load_kernel_conv2),
        .input_valid       (input_valid),
        .se_out_valid      (se_out_valid),
        .se_out_data       (se_out_data),
        .result_valid      (result_valid),
        .result_data       (result_data),
        .out_count         (out_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_ctl(input logic [1:0] kind, input int data);
        ctl_t e;
        e.kind = kind;
        e.data = 16'(data);
        exp_q.push_back(e);
    endtask

    // Memory holds mem[a] = a; garbage when no read was issued, so stray timing shows up.
    initial begin
        forever begin
            @(posedge clk);
            mem_rd_data <= mem_rd_en ? {4'h0, mem_addr} : 16'hDEAD;
        end
    end

    // SE model: echoes one output per accepted pixel after se_lat cycles, or (deferred)
    // releases se_total outputs back-to-back once the stream has ended.
    initial begin
        bit   go;
        logic prev_l1;
        prev_l1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            se_out_valid = 1'b0;
            se_out_data  = 16'h0;
            if (se_run && input_valid) begin
                in_seen++;
                in_times.push_back(mcyc);
            end
            if (se_idle_pulse && !busy) begin
                se_out_valid  = 1'b1;
                se_out_data   = 16'hBAD1;
                se_idle_pulse = 0;
            end else if (se_gap_pulse && prev_l1 && !load_kernel_conv1) begin
                se_out_valid = 1'b1;
                se_out_data  = 16'hBAD2;
                se_gap_pulse = 0;
            end else if (se_run && out_sent < se_total) begin
                if (se_defer) go = (in_seen == NP) && !input_valid;
                else          go = (in_times.size() > 0) && (mcyc >= in_times[0] + se_lat);
                if (go) begin
                    if (!se_defer) void'(in_times.pop_front());
                    se_out_valid = 1'b1;
                    se_out_data  = 16'h4000 ^ 16'(out_sent * 5);
                    if (out_sent < NP) res_q.push_back(se_out_data);
                    out_sent++;
                end
            end
            prev_l1 = load_kernel_conv1;
        end
    end

    // Control-stream and result monitor.
    always @(negedge clk) begin
        int   ones;
        logic [1:0] kind;
        ctl_t e;
        logic [15:0] r;
        ones = int'(load_kernel_conv1) + int'(load_kernel_conv2) + int'(input_valid);
        check("ctl_exclusive", 32'(ones <= 1), 32'd1);
        if (ones == 0) begin
            check("in_data_zero_when_idle", 32'(in_data), 32'd0);
        end else begin
            kind = load_kernel_conv1 ? 2'd1 : (load_kernel_conv2 ? 2'd2 : 2'd3);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_se_control");
            end else begin
                e = exp_q.pop_front();
                check("ctl_kind", 32'(kind), 32'(e.kind));
                check("in_data", 32'(in_data), 32'(e.data));
            end
        end
        if (result_valid) begin
            if (res_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                r = res_q.pop_front();
                check("result_data", 32'(result_data), 32'(r));
            end
        end
    end

    task automatic push_stream();
        push_ctl(2'd1, 0);
        for (int k = 0; k < NW; k++) push_ctl(2'd1, k);
        push_ctl(2'd1, NW - 1);
        push_ctl(2'd2, 0);
        for (int k = 0; k < NW; k++) push_ctl(2'd2, NW + k);
        push_ctl(2'd2, 2 * NW - 1);
        for (int p = 0; p < NP; p++) push_ctl(2'd3, 2 * NW + p);
    endtask

    task automatic arm_model(input int lat, input int total, input bit defer);
        in_seen  = 0;
        out_sent = 0;
        in_times.delete();
        se_lat   = lat;
        se_total = total;
        se_defer = defer;
        se_run   = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_in_data"}, 32'(in_data), 0);
        check({tag, "_load1"}, 32'(load_kernel_conv1), 0);
        check({tag, "_load2"}, 32'(load_kernel_conv2), 0);
        check({tag, "_input_valid"}, 32'(input_valid), 0);
        check({tag, "_result_valid"}, 32'(result_valid), 0);
        check({tag, "_result_data"}, 32'(result_data), 0);
        check({tag, "_out_count"}, 32'(out_count), 0);
    endtask

    // One complete run. exp_gap = cycles from last input_valid cycle to the DONE cycle.
    task automatic run(input int lat, input int total, input bit defer, input bit inj,
                       input int exp_count, input bit exp_err, input int exp_gap,
                       input string tag);
        int cyc, last_iv, gapc, n_l1, n_iv;
        bit seen_iv, got_done;
        cyc = 0; last_iv = 0; gapc = 0; n_l1 = 0; n_iv = 0; seen_iv = 0; got_done = 0;
        push_stream();
        arm_model(lat, total, defer);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check({tag, "_setup_rd_en"}, 32'(mem_rd_en), 1);
        check({tag, "_setup_addr"}, 32'(mem_addr), 0);
        check({tag, "_busy"}, 32'(busy), 1);
        while (cyc < 5000) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (load_kernel_conv1) n_l1++;
            if (input_valid) begin
                n_iv++;
                seen_iv = 1;
                last_iv = cyc;
            end
            if (busy && !load_kernel_conv1 && !load_kernel_conv2 && !input_valid &&
                n_l1 > 0 && !seen_iv) gapc++;
            start = inj && (n_l1 == 10 || n_iv == 500);
            @(posedge clk); #2;
            cyc++;
        end
        start = 1'b0;
        if (!got_done) begin
            fail_now({tag, "_done_timeout"});
        end else begin
            check({tag, "_out_count"}, 32'(out_count), 32'(exp_count));
            check({tag, "_error"}, 32'(error), 32'(exp_err));
            check({tag, "_done_latency"}, 32'(cyc - last_iv), 32'(exp_gap));
            check({tag, "_gap_cycles"}, 32'(gapc), 1);
            check({tag, "_load1_cycles"}, 32'(n_l1), 32'(NW + 2));
            check({tag, "_stream_cycles"}, 32'(n_iv), 32'(NP));
            @(posedge clk); #2;
            check({tag, "_done_pulse"}, 32'(done), 0);
            check({tag, "_idle"}, 32'(busy), 0);
            repeat (12) @(posedge clk);
            #2;
            check({tag, "_count_hold"}, 32'(out_count), 32'(exp_count));
            check({tag, "_error_hold"}, 32'(error), 32'(exp_err));
        end
        se_run = 0;
        check({tag, "_ctl_queue_empty"}, 32'(exp_q.size()), 0);
        check({tag, "_res_queue_empty"}, 32'(res_q.size()), 0);
        exp_q.delete();
        res_q.delete();
    endtask

    initial begin
        int cyc;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Basic run, SE latency 3 so the tail lands in DRAIN.
        run(3, NP, 0, 0, NP, 0, 4, "t1");

        // Ignored start pulses in W1_LOAD and STREAM.
        run(1, NP, 0, 1, NP, 0, 2, "t2");

        // Reset mid-stream aborts at once.
        push_stream();
        arm_model(2, NP, 0);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 0;
        while (in_seen < 300 && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("t3_reached_stream", 32'(in_seen), 300);
        rst = 1'b1;
        #1 chk_all_zero("t3_abort");
        se_run = 0;
        exp_q.delete();
        res_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check("t3_idle_after_reset", 32'(busy), 0);

        // Restart from address 0; last output coincides with the last STREAM cycle.
        run(0, NP, 0, 0, NP, 0, 1, "t6");

        // Pulses in IDLE and GAP are dropped; 1030 deferred outputs, first 1024 counted.
        se_idle_pulse = 1;
        repeat (3) @(posedge clk);
        #2;
        check("t4_idle_count", 32'(out_count), 32'(NP));
        se_gap_pulse = 1;
        run(0, NP + 6, 1, 0, NP, 0, NP + 1, "t4");

`ifdef SE_FEEDER_TIMEOUT_EN
        // SE stops after 500 outputs: 16 idle DRAIN cycles then DONE with error.
        run(2, 500, 0, 0, 500, 1, TO + 1, "t5");
        // Next start clears the sticky error.
        run(1, NP, 0, 0, NP, 0, 2, "t5b");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
